// File: rtl/nibble_add_seq.sv
// nibble_add_seq: wide adder sequenced one nibble per clock through a single 4-bit CLA cell.
// Ports: clk, rst (async, active-high); in_valid/in_ready with a, b, cin (and op_sub when SUB_EN);
// out_valid/out_ready with sum, cout, ovf; busy is high in RUN or DONE.
// Optional feature macro: SUB_EN adds op_sub for a - b.

module nibble_cla4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);
    logic [3:0] g, p;
    logic [4:0] c;
    assign g = a & b;
    assign p = a ^ b;
    assign c[0] = cin;
    assign c[1] = g[0] | (p[0] & cin);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
    assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & cin);
    assign sum  = p ^ c[3:0];
    assign cout = c[4];
endmodule

module nibble_add_seq #(
    parameter int NIBBLES = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [4*NIBBLES-1:0] a,
    input  logic [4*NIBBLES-1:0] b,
    input  logic                 cin,
`ifdef SUB_EN
    input  logic                 op_sub,
`endif
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [4*NIBBLES-1:0] sum,
    output logic                 cout,
    output logic                 ovf,
    output logic                 busy
);
    localparam int W  = 4 * NIBBLES;
    localparam int CW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state, state_nx;

    logic [W-1:0]  a_reg, b_reg;
    logic          carry;
    logic [CW-1:0] k;
    logic [3:0]    cell_sum;
    logic          cell_cout;
    logic          last;
    logic [W-1:0]  b_eff;
    logic          cin_eff;

`ifdef SUB_EN
    // Subtraction as a + ~b + 1; the external carry-in is ignored.
    assign b_eff   = op_sub ? ~b : b;
    assign cin_eff = op_sub ? 1'b1 : cin;
`else
    assign b_eff   = b;
    assign cin_eff = cin;
`endif

    assign last = (k == CW'(NIBBLES - 1));

    nibble_cla4 u_cell (
        .a    (a_reg[{k, 2'b00} +: 4]),
        .b    (b_reg[{k, 2'b00} +: 4]),
        .cin  (carry),
        .sum  (cell_sum),
        .cout (cell_cout)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
        busy      = (state != IDLE);
        if (state == IDLE && in_valid) state_nx = RUN;
        if (state == RUN && last)      state_nx = DONE;
        if (state == DONE && out_ready) state_nx = IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_reg <= '0;
            b_reg <= '0;
            carry <= 1'b0;
            k     <= '0;
            sum   <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
        end else if (state == IDLE && in_valid) begin
            a_reg <= a;
            b_reg <= b_eff;
            carry <= cin_eff;
            k     <= '0;
            sum   <= '0;
        end else if (state == RUN) begin
            sum[{k, 2'b00} +: 4] <= cell_sum;
            carry <= cell_cout;
            k     <= k + 1'b1;
            if (last) begin
                cout <= cell_cout;
                // carry still holds the carry into the MSB nibble this cycle
                ovf  <= carry ^ cell_cout;
            end
        end
    end
endmodule

// File: tb/tb_nibble_add_seq.sv
// tb_nibble_add_seq: directed self-checking bench for nibble_add_seq (NIBBLES=4).
module tb_nibble_add_seq;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic        cin = 1'b0;
`ifdef SUB_EN
    logic        op_sub = 1'b0;
`endif
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
    logic        busy;
    int          checks = 0;
    int          passed = 0;
    int          lat;
    logic        seen;

    nibble_add_seq #(.NIBBLES(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
`ifdef SUB_EN
        .op_sub    (op_sub),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Accept on the next edge, then count edges (accept edge included) until out_valid.
    task automatic start(input logic [15:0] av, input logic [15:0] bv, input logic cv, output int edges);
        a = av;
        b = bv;
        cin = cv;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        edges = 1;
        while (!out_valid && edges < 20) begin
            step();
            edges++;
        end
    endtask

    task automatic finish_op();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("idle_in_ready", in_ready, 1);
        chk("idle_out_valid", out_valid, 0);
    endtask

    initial begin
        #1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_sum", sum, 0);
        chk("rst_cout", cout, 0);
        chk("rst_ovf", ovf, 0);
        step();
        step();
        rst = 1'b0;
        out_ready = 1'b1;
        step();
        chk("idle_out_ready_noeffect", {in_ready, out_valid, busy}, 3'b100);
        out_ready = 1'b0;

        start(16'h1234, 16'h4321, 1'b0, lat);
        chk("lat_1234", lat, 5);
        chk("sum_1234", sum, 16'h5555);
        chk("cout_1234", cout, 0);
        chk("ovf_1234", ovf, 0);
        chk("busy_done", busy, 1);
        chk("in_ready_done", in_ready, 0);
        finish_op();

        start(16'hFFFF, 16'h0001, 1'b0, lat);
        chk("sum_ffff_1", sum, 16'h0000);
        chk("cout_ffff_1", cout, 1);
        chk("ovf_ffff_1", ovf, 0);
        finish_op();

        start(16'h7FFF, 16'h0001, 1'b0, lat);
        chk("sum_7fff_1", sum, 16'h8000);
        chk("cout_7fff_1", cout, 0);
        chk("ovf_7fff_1", ovf, 1);
        finish_op();

        start(16'hFFFF, 16'h0000, 1'b1, lat);
        chk("sum_ffff_cin", sum, 16'h0000);
        chk("cout_ffff_cin", cout, 1);
        chk("ovf_ffff_cin", ovf, 0);
        finish_op();

        start(16'h1234, 16'h1111, 1'b0, lat);
        chk("sum_bp", sum, 16'h2345);
        for (int i = 0; i < 10; i++) begin
            if (i == 3) begin
                a = 16'hFFFF;
                b = 16'hFFFF;
                cin = 1'b1;
                in_valid = 1'b1;
            end
            step();
            in_valid = 1'b0;
            chk("bp_out_valid", out_valid, 1);
            chk("bp_in_ready", in_ready, 0);
            chk("bp_sum", sum, 16'h2345);
            chk("bp_cout", cout, 0);
        end
        finish_op();

        a = 16'h1234;
        b = 16'h4321;
        cin = 1'b0;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        step();
        chk("mid_busy", busy, 1);
        chk("mid_partial", sum, 16'h0055);
        rst = 1'b1;
        #1;
        chk("mrst_in_ready", in_ready, 1);
        chk("mrst_out_valid", out_valid, 0);
        chk("mrst_busy", busy, 0);
        chk("mrst_sum", sum, 0);
        chk("mrst_cout_ovf", {cout, ovf}, 2'b00);
        step();
        rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            seen = seen | out_valid;
        end
        chk("mrst_no_valid", seen, 0);
        start(16'h0F0F, 16'h00F1, 1'b0, lat);
        chk("lat_after_rst", lat, 5);
        chk("sum_0f0f", sum, 16'h1000);
        chk("cout_0f0f", cout, 0);
        finish_op();

`ifdef SUB_EN
        op_sub = 1'b1;
        start(16'h0005, 16'h0007, 1'b1, lat);
        chk("sub_sum_5_7", sum, 16'hFFFE);
        chk("sub_cout_5_7", cout, 0);
        finish_op();
        start(16'h8000, 16'h0001, 1'b0, lat);
        chk("sub_sum_8000_1", sum, 16'h7FFF);
        chk("sub_cout_8000_1", cout, 1);
        chk("sub_ovf_8000_1", ovf, 1);
        finish_op();
        op_sub = 1'b0;
`endif

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
